fetch_unit: RTL and testbench

//   Instruction fetch stage between the program counter and decode. Drives the

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: ROM port, redirect input, fetch enable and the
// decode valid/ready handshake.
//   master : the fetch unit (drives rom_pc, dec_valid, dec_instr, dec_pc)
//   slave  : the surrounding core (drives fetch_en, rom_instr, br_*, dec_ready)
interface fetch_unit_if #(
  parameter int unsigned PC_W = 30
);
  logic            fetch_en;
  logic [PC_W-1:0] rom_pc;
  logic [15:0]     rom_instr;
  logic            br_valid;
  logic [PC_W-1:0] br_target;
  logic            dec_valid;
  logic            dec_ready;
  logic [15:0]     dec_instr;
  logic [PC_W-1:0] dec_pc;

  modport master (
    input  fetch_en, rom_instr, br_valid, br_target, dec_ready,
    output rom_pc, dec_valid, dec_instr, dec_pc
  );

  modport slave (
    output fetch_en, rom_instr, br_valid, br_target, dec_ready,
    input  rom_pc, dec_valid, dec_instr, dec_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Drives a registered word PC into a combinational
// ROM, buffers {instr, pc} in a FIFO_DEPTH-entry FIFO and hands the head to
// decode over valid/ready. A branch redirect flushes the FIFO and reloads
// the PC; it has priority over push and pop.
// Ports:
//   sys_clk : clock, rising edge
//   sys_rst : asynchronous active-high reset
//   bus     : fetch_unit_if master (ROM, redirect, enable, decode handshake)
module fetch_unit #(
  parameter int unsigned     PC_W       = 30,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  fetch_unit_if.master bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [15:0]     instr;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PC_W-1:0]  pc_q, pc_d;

  logic full, empty, push, pop;

  // Flags come only from the registered count, so push never depends on
  // dec_ready in the same cycle.
  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.fetch_en && !full && !bus.br_valid;
  assign pop   = !empty && bus.dec_ready && !bus.br_valid;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pc_d     = pc_q;
    if (bus.br_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      pc_d     = bus.br_target;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        pc_d     = pc_q + PC_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= RESET_PC;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= '{instr: bus.rom_instr, pc: pc_q};
    end
  end

  assign bus.rom_pc    = pc_q;
  assign bus.dec_valid = !empty;
  assign bus.dec_instr = mem_q[rd_ptr_q].instr;
  assign bus.dec_pc    = mem_q[rd_ptr_q].pc;
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int unsigned     PC_W     = 30;
  localparam logic [PC_W-1:0] RESET_PC = '0;
  localparam int unsigned     DEPTH    = 2;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  fetch_unit_if #(.PC_W(PC_W)) bus ();

  fetch_unit #(
    .PC_W(PC_W),
    .RESET_PC(RESET_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus(bus.master)
  );

  // ROM contents: pseudo-random table mixed with the address
  logic [15:0] rom_tbl [16];
  function automatic logic [15:0] rom_f(input logic [PC_W-1:0] pc);
    logic [PC_W-1:0] hi;
    hi = pc >> 16;
    return rom_tbl[pc[3:0]] ^ pc[15:0] ^ hi[15:0];
  endfunction
  assign bus.rom_instr = rom_f(bus.rom_pc);

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a queue of {instr, pc} and the fetch PC
  typedef struct {
    logic [15:0]     instr;
    logic [PC_W-1:0] pc;
  } ent_t;
  ent_t            m_q[$];
  logic [PC_W-1:0] m_pc;

  task automatic model_reset();
    m_q.delete();
    m_pc = RESET_PC;
  endtask

  task automatic model_edge(input logic en, input logic br, input logic [PC_W-1:0] tgt,
                            input logic rdy);
    bit was_full, was_empty;
    was_full  = (m_q.size() == DEPTH);
    was_empty = (m_q.size() == 0);
    if (br) begin
      m_q.delete();
      m_pc = tgt;
    end else begin
      if (!was_empty && rdy) void'(m_q.pop_front());
      if (en && !was_full) begin
        m_q.push_back('{instr: rom_f(m_pc), pc: m_pc});
        m_pc = m_pc + 1'b1;
      end
    end
  endtask

  task automatic compare();
    check("dec_valid", 64'(bus.dec_valid), 64'(m_q.size() != 0));
    check("rom_pc", 64'(bus.rom_pc), 64'(m_pc));
    if (m_q.size() != 0) begin
      check("dec_pc", 64'(bus.dec_pc), 64'(m_q[0].pc));
      check("dec_instr", 64'(bus.dec_instr), 64'(m_q[0].instr));
    end
  endtask

  // Called at a negedge: drive, predict, cross the posedge, compare.
  task automatic step(input logic en, input logic br, input logic [PC_W-1:0] tgt,
                      input logic rdy);
    bus.fetch_en  = en;
    bus.br_valid  = br;
    bus.br_target = tgt;
    bus.dec_ready = rdy;
    model_edge(en, br, tgt, rdy);
    @(posedge sys_clk);
    @(negedge sys_clk);
    compare();
  endtask

  // Asynchronous reset pulse between edges, checked before any clock edge.
  task automatic areset();
    bus.fetch_en  = 1'b0;
    bus.br_valid  = 1'b0;
    bus.dec_ready = 1'b0;
    #2 sys_rst = 1'b1;
    #1;
    check("arst_valid", 64'(bus.dec_valid), 64'd0);
    check("arst_pc", 64'(bus.rom_pc), 64'(RESET_PC));
    check("arst_dpc", 64'(bus.dec_pc), 64'd0);
    model_reset();
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    compare();
  endtask

  initial begin
    logic [PC_W-1:0] tgt;
    logic [PC_W-1:0] all1;
    all1 = '1;
    for (int i = 0; i < 16; i++) rom_tbl[i] = 16'($urandom);
    bus.fetch_en  = 1'b0;
    bus.br_valid  = 1'b0;
    bus.br_target = '0;
    bus.dec_ready = 1'b0;
    model_reset();

    #12;
    check("rst_valid", 64'(bus.dec_valid), 64'd0);
    check("rst_pc", 64'(bus.rom_pc), 64'(RESET_PC));
    check("rst_instr", 64'(bus.dec_instr), 64'd0);
    check("rst_dpc", 64'(bus.dec_pc), 64'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // 1: streaming, one per cycle
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, '0, 1'b1);
    check("t1_pc", 64'(bus.dec_pc), 64'd6);

    // 2: stall fills to depth, PC holds, then drain in order
    areset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b0);
    check("t2_rom_pc", 64'(bus.rom_pc), 64'd2);
    check("t2_head", 64'(bus.dec_pc), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b1);

    // 3: redirect with two entries buffered
    areset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, PC_W'(5), 1'b1);
    check("t3_flush", 64'(bus.dec_valid), 64'd0);
    step(1'b1, 1'b0, '0, 1'b1);
    check("t3_tgt", 64'(bus.dec_pc), 64'd5);
    step(1'b1, 1'b0, '0, 1'b1);

    // 4: redirect while full and stalled
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, PC_W'(40), 1'b0);
    check("t4_flush", 64'(bus.dec_valid), 64'd0);
    step(1'b1, 1'b0, '0, 1'b0);
    check("t4_tgt", 64'(bus.dec_pc), 64'd40);

    // 5: PC wrap
    step(1'b0, 1'b1, all1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    check("t5_top", 64'(bus.dec_pc), 64'(all1));
    step(1'b0, 1'b0, '0, 1'b1);
    check("t5_wrap", 64'(bus.dec_pc), 64'd0);

    // 6: async reset mid-stream, then restart
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1);
    areset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) tgt = all1 - PC_W'($urandom_range(0, 3));
      else tgt = PC_W'($urandom);
      if ($urandom_range(0, 99) == 0) areset();
      else step(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) == 0), tgt,
                1'($urandom_range(0, 9) < 6));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
